packet_bigword_mem: RTL and testbench
=====================================

# packet_bigword_mem

Double-banked packet buffer between the AXI-Stream snooper input and the filter CPU's read-size adapter. Incoming 32-bit big-endian beats are written into even and odd word banks. A single CPU word address then returns the 64-bit `{word[A], word[A+1]}` with one-cycle latency, which is the `bigword` the adapter slices for unaligned B/H/W loads. A three-state ownership FSM hands each complete packet to the CPU and frees the buffer when the CPU is done.

## Interface
- `BYTE_ADDR_WIDTH`, default 12: packet byte-address width.
  - Word address width is `BYTE_ADDR_WIDTH-2`.
  - Total depth is 2^(`BYTE_ADDR_WIDTH-2`) words.
  - Each bank holds half of that depth.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  32  packet beat; the first byte on the wire is `[31:24]`.
- `s_axis_tkeep`  in  4  byte enables; contiguous from MSB (4'b1000, 4'b1100, 4'b1110, 4'b1111).
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accepted when tvalid && tready.
- `s_axis_tlast`  in  1  last beat of the packet.
- `rd_word_addr`  in  `BYTE_ADDR_WIDTH-2`  CPU word address A.
- `rd_en`  in  1  CPU read enable.
- `bigword`  out  64  `{word[A], word[A+1]}`, registered.
- `pkt_ready`  out  1  a complete packet is owned by the CPU.
- `pkt_len`  out  `BYTE_ADDR_WIDTH+1`  packet length in bytes.
- `pkt_truncated`  out  1  the packet overflowed the buffer.
- `cpu_done`  in  1  single-cycle pulse: CPU releases the buffer.

## Operation
- FSM states:
  - `ACCEPT`: receiving beats; `tready`=1.
  - `READY`: CPU owns the buffer; `pkt_ready`=1, `tready`=0.
  - `RST_HOLD`: entered during `rst`; exits to `ACCEPT` on the first non-reset cycle.
- `ACCEPT` → `READY` on an accepted beat with `tlast`=1.
- `READY` → `ACCEPT` on `cpu_done`=1.
- `cpu_done` is ignored in `ACCEPT`.
- Write side:
  - Beat counter W starts at 0 and increments per accepted beat.
  - When W[0]=0, the beat goes to even bank at address W>>1; when W[0]=1, to odd bank at address W>>1.
- Length on the last beat: `pkt_len` = 4·(beats−1) + popcount(`tkeep`).
  - Non-last beats are counted as 4 bytes regardless of `tkeep`.
  - Width is `BYTE_ADDR_WIDTH+1` bits, so a full buffer (2^`BYTE_ADDR_WIDTH` bytes) is representable.
- Overflow:
  - Beats with W ≥ depth are accepted (`tready` stays 1) but not written.
  - Such a beat sets `pkt_truncated`.
  - `pkt_len` saturates at 2^`BYTE_ADDR_WIDTH`.
- Entering `ACCEPT` from `READY` clears W, `pkt_len` and `pkt_truncated`.
- Read side, for address A:
  - Even-bank address = (A+1)>>1; odd-bank address = A>>1, both truncated to bank width.
  - A[0] is registered alongside.
  - If registered A[0]=0: `bigword = {even, odd}`.
  - If registered A[0]=1: `bigword = {odd, even}`.
- Wrap-around: for A = depth−1, the low half is word 0. This is deterministic and is not an error.
- Reads are permitted in any state. In `ACCEPT` they return current RAM contents with no coherence guarantee.
- A read and a write to the same word in the same cycle return the old data.
- RAM contents are not cleared by reset.

## Timing
- Reset values:
  - `s_axis_tready`=0, `pkt_ready`=0, `pkt_len`=0, `pkt_truncated`=0, `bigword`=0.
  - State = `RST_HOLD`.
- `s_axis_tready`=1 on the first cycle after `rst` deasserts.
- Read latency is 1 cycle: with `rd_word_addr`/`rd_en` sampled at edge N, `bigword` is valid after edge N and stays valid until the next edge with `rd_en`=1.
- `bigword` holds its value while `rd_en`=0.
- Last beat accepted at edge N: after edge N, `pkt_ready`=1, `tready`=0 and `pkt_len` is final.
- `cpu_done` sampled at edge M: after edge M, `pkt_ready`=0 and `tready`=1. A beat may be accepted at edge M+1.
- Back-to-back packets therefore lose no cycles beyond the CPU hold time.
- `rst` mid-packet or in `READY` abandons the packet. Outputs take reset values after that edge.
- Every interface output except `bigword` (state-derived `tready`, `pkt_ready`) is a direct function of registered state. There are no combinational input-to-output paths.

## Test plan
- **Basic packet:** reset, then 3 beats 0x01020304, 0x05060708, 0x090A0B0C with tlast on the third and tkeep=4'b1111 → `pkt_ready`=1 one cycle later, `pkt_len`=12, `tready`=0.
- **Short last beat:** 2 beats, last tkeep=4'b1100 → `pkt_len`=6.
- **Word-pair reads (basic packet loaded):**
  - read A=0 → `bigword`=0x0102030405060708 on the next cycle.
  - A=1 → 0x05060708090A0B0C.
  - A=2 → upper half 0x090A0B0C.
- **Overflow:** stream depth+5 beats at 4 bytes each → `pkt_truncated`=1, `pkt_len`=2^`BYTE_ADDR_WIDTH`, word[0] intact; read A=depth−1 returns word[0] in the low half.
- **Handoff:** pulse `cpu_done` during `ACCEPT` → no effect. Pulse it in `READY` → `tready`=1 next cycle; a second packet loads with `pkt_len` and `pkt_truncated` cleared.
- **Reset:**
  - `rst` mid-packet → all outputs at reset values and no `pkt_ready`.
  - A fresh packet after release reports the correct length starting from W=0.

Source files
------------

// File: rtl/packet_bigword_mem.sv
// rtl/packet_bigword_mem.sv - double-banked packet buffer with 64-bit word-pair CPU reads
// Beats fill even/odd word banks; the CPU reads {word[A], word[A+1]} once the packet is handed over.
module packet_bigword_mem #(
   parameter int BYTE_ADDR_WIDTH = 12
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  s_axis_tdata,
   input  logic [3:0]                   s_axis_tkeep,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast,
   input  logic [BYTE_ADDR_WIDTH-3:0]   rd_word_addr,
   input  logic                         rd_en,
   output logic [63:0]                  bigword,
   output logic                         pkt_ready,
   output logic [BYTE_ADDR_WIDTH:0]     pkt_len,
   output logic                         pkt_truncated,
   input  logic                         cpu_done
);

   localparam int WA      = BYTE_ADDR_WIDTH - 2;
   localparam int BA      = WA - 1;
   localparam int DEPTH_B = 1 << BA;

   localparam logic [1:0] S_RST_HOLD = 2'd0;
   localparam logic [1:0] S_ACCEPT   = 2'd1;
   localparam logic [1:0] S_READY    = 2'd2;

   localparam logic [WA:0]              W_ONE   = {{WA{1'b0}}, 1'b1};
   localparam logic [BYTE_ADDR_WIDTH:0] LEN_MAX = {1'b1, {BYTE_ADDR_WIDTH{1'b0}}};

   logic [1:0]                 r_state;
   logic [WA:0]                r_w;
   logic [BYTE_ADDR_WIDTH:0]   r_len;
   logic                       r_trunc;
   logic [31:0]                r_even_mem [DEPTH_B];
   logic [31:0]                r_odd_mem  [DEPTH_B];
   logic [31:0]                r_even_q;
   logic [31:0]                r_odd_q;
   logic                       r_sel;

   logic                       w_accept;
   logic                       w_overflow;
   logic                       w_wr_en;
   logic [2:0]                 w_keep_cnt;
   logic [BYTE_ADDR_WIDTH:0]   w_len_final;
   logic [BA-1:0]              w_even_addr;
   logic [BA-1:0]              w_odd_addr;

   // r_w saturates at depth, so its top bit alone marks an overflowing beat
   assign w_overflow  = r_w[WA];
   assign w_accept    = (r_state == S_ACCEPT) && s_axis_tvalid;
   assign w_wr_en     = w_accept && !w_overflow && !rst;
   assign w_keep_cnt  = {2'b00, s_axis_tkeep[3]} + {2'b00, s_axis_tkeep[2]}
                      + {2'b00, s_axis_tkeep[1]} + {2'b00, s_axis_tkeep[0]};
   assign w_len_final = w_overflow ? LEN_MAX
                      : ({1'b0, r_w[WA-1:0], 2'b00} + {{(BYTE_ADDR_WIDTH-2){1'b0}}, w_keep_cnt});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RST_HOLD;
         r_w     <= '0;
         r_len   <= '0;
         r_trunc <= 1'b0;
      end else begin
         case (r_state)
            S_RST_HOLD: r_state <= S_ACCEPT;
            S_ACCEPT: begin
               if (w_accept) begin
                  if (w_overflow) r_trunc <= 1'b1;
                  else            r_w     <= r_w + W_ONE;
                  if (s_axis_tlast) begin
                     r_len   <= w_len_final;
                     r_state <= S_READY;
                  end
               end
            end
            S_READY: begin
               if (cpu_done) begin
                  r_state <= S_ACCEPT;
                  r_w     <= '0;
                  r_len   <= '0;
                  r_trunc <= 1'b0;
               end
            end
            default: r_state <= S_RST_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         if (r_w[0]) r_odd_mem[r_w[WA-1:1]]  <= s_axis_tdata;
         else        r_even_mem[r_w[WA-1:1]] <= s_axis_tdata;
      end
   end

   // (A+1)>>1 == (A>>1) + A[0]; wraps to word 0 at the top of the buffer
   assign w_odd_addr  = rd_word_addr[WA-1:1];
   assign w_even_addr = rd_word_addr[WA-1:1] + {{(BA-1){1'b0}}, rd_word_addr[0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_even_q <= '0;
         r_odd_q  <= '0;
         r_sel    <= 1'b0;
      end else if (rd_en) begin
         r_even_q <= r_even_mem[w_even_addr];
         r_odd_q  <= r_odd_mem[w_odd_addr];
         r_sel    <= rd_word_addr[0];
      end
   end

   assign bigword       = r_sel ? {r_odd_q, r_even_q} : {r_even_q, r_odd_q};
   assign s_axis_tready = (r_state == S_ACCEPT);
   assign pkt_ready     = (r_state == S_READY);
   assign pkt_len       = r_len;
   assign pkt_truncated = r_trunc;

endmodule

// File: tb/tb_packet_bigword_mem.sv
// tb/tb_packet_bigword_mem.sv - self-checking bench for packet_bigword_mem
// Table vectors plus random packets checked against a word-array model of the buffer.
module tb_packet_bigword_mem;

   localparam int BAW   = 8;
   localparam int WA    = BAW - 2;
   localparam int DEPTH = 1 << WA;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      s_axis_tdata;
   logic [3:0]       s_axis_tkeep;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic             s_axis_tlast;
   logic [WA-1:0]    rd_word_addr;
   logic             rd_en;
   logic [63:0]      bigword;
   logic             pkt_ready;
   logic [BAW:0]     pkt_len;
   logic             pkt_truncated;
   logic             cpu_done;

   packet_bigword_mem #(.BYTE_ADDR_WIDTH(BAW)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .rd_word_addr(rd_word_addr), .rd_en(rd_en), .bigword(bigword),
      .pkt_ready(pkt_ready), .pkt_len(pkt_len), .pkt_truncated(pkt_truncated),
      .cpu_done(cpu_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         beats;
      logic [3:0] keep;
      logic [8:0] len;
      logic       trunc;
   } pkt_vec_t;

   typedef struct {
      logic [WA-1:0] a;
      logic [63:0]   bw;
      logic [63:0]   mask;
   } rd_vec_t;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_mem [DEPTH];
   bit          model_known [DEPTH];
   int          model_beats = 0;
   logic [3:0]  kp [4];
   pkt_vec_t    pv [6];
   rd_vec_t     rv [3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] exp_len(input int beats, input logic [3:0] keep);
      if (beats > DEPTH) return 9'(1 << BAW);
      return 9'(4 * (beats - 1) + $countones(keep));
   endfunction

   task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
      int n = 0;
      s_axis_tdata  = data;
      s_axis_tkeep  = keep;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && n < 20) begin
         step();
         n++;
      end
      if (!s_axis_tready) chk("tready_timeout", {63'd0, s_axis_tready}, 64'd1);
      step();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (model_beats < DEPTH) begin
         model_mem[model_beats]   = data;
         model_known[model_beats] = 1'b1;
      end
      model_beats++;
   endtask

   task automatic send_packet(input int beats, input logic [3:0] last_keep);
      for (int i = 0; i < beats; i++)
         send_beat($urandom, (i == beats - 1) ? last_keep : kp[$urandom_range(0, 3)], i == beats - 1);
      chk("pkt_ready", {63'd0, pkt_ready}, 64'd1);
      chk("tready_ready", {63'd0, s_axis_tready}, 64'd0);
      chk("pkt_len", {55'd0, pkt_len}, {55'd0, exp_len(beats, last_keep)});
      chk("pkt_trunc", {63'd0, pkt_truncated}, {63'd0, beats > DEPTH});
   endtask

   task automatic release_pkt();
      cpu_done = 1'b1;
      step();
      cpu_done = 1'b0;
      model_beats = 0;
      chk("rel_pkt_ready", {63'd0, pkt_ready}, 64'd0);
      chk("rel_tready", {63'd0, s_axis_tready}, 64'd1);
      chk("rel_len", {55'd0, pkt_len}, 64'd0);
      chk("rel_trunc", {63'd0, pkt_truncated}, 64'd0);
   endtask

   task automatic rd_check(input logic [WA-1:0] a);
      int          b = (int'(a) + 1) % DEPTH;
      logic [63:0] exp;
      rd_word_addr = a;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      exp = {model_mem[a], model_mem[b]};
      if (model_known[a] && model_known[b]) begin
         chk("read", bigword, exp);
         rd_word_addr = WA'($urandom);
         step();
         chk("read_hold", bigword, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] bw_before;
      kp[0] = 4'b1000; kp[1] = 4'b1100; kp[2] = 4'b1110; kp[3] = 4'b1111;
      pv[0] = '{3,  4'b1111, 9'd12,  1'b0};
      pv[1] = '{2,  4'b1100, 9'd6,   1'b0};
      pv[2] = '{1,  4'b1000, 9'd1,   1'b0};
      pv[3] = '{5,  4'b1110, 9'd19,  1'b0};
      pv[4] = '{64, 4'b1111, 9'd256, 1'b0};
      pv[5] = '{65, 4'b1000, 9'd256, 1'b1};
      rv[0] = '{6'd0, 64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF};
      rv[1] = '{6'd1, 64'h05060708090A0B0C, 64'hFFFFFFFFFFFFFFFF};
      rv[2] = '{6'd2, 64'h090A0B0C00000000, 64'hFFFFFFFF00000000};
      for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

      rst = 1'b1; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0; rd_word_addr = '0; rd_en = 1'b0; cpu_done = 1'b0;
      repeat (3) step();
      chk("rst_tready", {63'd0, s_axis_tready}, 64'd0);
      chk("rst_pkt_ready", {63'd0, pkt_ready}, 64'd0);
      chk("rst_len", {55'd0, pkt_len}, 64'd0);
      chk("rst_trunc", {63'd0, pkt_truncated}, 64'd0);
      chk("rst_bigword", bigword, 64'd0);
      rst = 1'b0;
      step();
      chk("post_rst_tready", {63'd0, s_axis_tready}, 64'd1);

      // cpu_done while accepting must be ignored, even mid-packet
      cpu_done = 1'b1;
      step();
      cpu_done = 1'b0;
      chk("done_in_accept", {62'd0, pkt_ready, s_axis_tready}, 64'd1);

      send_beat(32'h01020304, 4'b1111, 1'b0);
      cpu_done = 1'b1;
      step();
      cpu_done = 1'b0;
      chk("done_mid_pkt", {62'd0, pkt_ready, s_axis_tready}, 64'd1);
      send_beat(32'h05060708, 4'b1111, 1'b0);
      send_beat(32'h090A0B0C, 4'b1111, 1'b1);
      chk("basic_pkt_ready", {63'd0, pkt_ready}, 64'd1);
      chk("basic_tready", {63'd0, s_axis_tready}, 64'd0);
      chk("basic_len", {55'd0, pkt_len}, 64'd12);
      repeat (2) step();
      chk("basic_len_stable", {55'd0, pkt_len}, 64'd12);

      for (int i = 0; i < 3; i++) begin
         rd_word_addr = rv[i].a;
         rd_en = 1'b1;
         step();
         rd_en = 1'b0;
         chk("rd_table", bigword & rv[i].mask, rv[i].bw);
      end
      release_pkt();

      for (int i = 0; i < 6; i++) begin
         send_packet(pv[i].beats, pv[i].keep);
         chk("tbl_len", {55'd0, pkt_len}, {55'd0, pv[i].len});
         chk("tbl_trunc", {63'd0, pkt_truncated}, {63'd0, pv[i].trunc});
         if (i == 5) begin
            rd_check(6'd0);
            rd_check(6'(DEPTH - 1));
         end
         release_pkt();
      end

      for (int p = 0; p < 6; p++) begin
         int beats = $urandom_range(1, DEPTH + 8);
         send_packet(beats, kp[$urandom_range(0, 3)]);
         for (int r = 0; r < 6; r++) rd_check(WA'($urandom));
         release_pkt();
      end

      send_packet(DEPTH + 5, 4'b1111);
      rd_check(6'd0);
      rd_check(6'(DEPTH - 1));
      chk("ovf_low_is_word0", {32'd0, bigword[31:0]}, {32'd0, model_mem[0]});
      release_pkt();
      send_packet(2, 4'b1111);
      chk("second_len", {55'd0, pkt_len}, 64'd8);
      chk("second_trunc", {63'd0, pkt_truncated}, 64'd0);
      release_pkt();

      send_beat(32'hDEADBEEF, 4'b1111, 1'b0);
      send_beat(32'hCAFEF00D, 4'b1111, 1'b0);
      rd_word_addr = 6'd0;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      bw_before = bigword;
      chk("pre_rst_read", bw_before, 64'hDEADBEEFCAFEF00D);
      rst = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h11111111;
      s_axis_tlast  = 1'b1;
      step();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      chk("midrst_outputs", {pkt_truncated, pkt_ready, s_axis_tready, pkt_len}, 64'd0);
      chk("midrst_bigword", bigword, 64'd0);
      rst = 1'b0;
      model_beats = 0;
      step();
      chk("midrst_release_tready", {63'd0, s_axis_tready}, 64'd1);
      send_packet(3, 4'b1110);
      chk("after_rst_len", {55'd0, pkt_len}, 64'd11);
      rd_check(6'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
